// File: rtl/pc_gen.sv
// pc_gen: fetch-group program counter for the IF stage.
//
// Produces the registered fetch PC for a FETCH_WIDTH-wide front end. Redirects
// are prioritised debug > exception > branch. A redirect that arrives while the
// stage is stalled is parked in a one-entry pending slot and applied on the
// first enabled cycle, so no redirect is lost.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   enable              advance the PC; low = stage stalled
//   debug_reset         synchronous restart to PC_INITIAL (beats everything)
//   is_debug/debug_new_pc, is_exception/exception_new_pc,
//   is_branch/branch_address      redirect requests with their targets
//   pc_reg              current fetch PC
//   pc_valid            pc_reg holds a fetchable PC (set one edge after reset)
//   slot_valid          per-slot valid mask of the current fetch group
//   pc_misaligned       pc_reg[1:0] != 0
//   redirect_pending    a captured redirect is waiting to be applied
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | no redirect parked; PC follows live requests or advances
// HOLD  | stalled redirect parked in pend_*; applied on next enable
module pc_gen #(
    parameter logic [31:0] PC_INITIAL  = 32'hbfc00000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   debug_reset,
    input  logic                   is_debug,
    input  logic [31:0]            debug_new_pc,
    input  logic                   is_exception,
    input  logic [31:0]            exception_new_pc,
    input  logic                   is_branch,
    input  logic [31:0]            branch_address,
    output logic [31:0]            pc_reg,
    output logic                   pc_valid,
    output logic [FETCH_WIDTH-1:0] slot_valid,
    output logic                   pc_misaligned,
    output logic                   redirect_pending
);

    localparam int          GROUP_BYTES = 4 * FETCH_WIDTH;
    localparam logic [31:0] GROUP_MASK  = ~(32'(GROUP_BYTES) - 32'd1);
    localparam int          OFS_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BR   = 2'd1;
    localparam logic [1:0] PRIO_EXC  = 2'd2;
    localparam logic [1:0] PRIO_DBG  = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_next;
    logic [1:0]  pend_prio, pend_prio_next;
    logic [31:0] pend_target, pend_target_next;

    logic [1:0]  live_prio;
    logic [31:0] live_target;
    logic [31:0] sel_target;
    logic [31:0] seq_pc;
    logic [31:0] slot_idx;

    // Highest-priority live request.
    always_comb begin
        live_prio   = PRIO_NONE;
        live_target = '0;
        if (is_debug) begin
            live_prio   = PRIO_DBG;
            live_target = debug_new_pc;
        end else if (is_exception) begin
            live_prio   = PRIO_EXC;
            live_target = exception_new_pc;
        end else if (is_branch) begin
            live_prio   = PRIO_BR;
            live_target = branch_address;
        end
    end

    // Parked redirect only wins when strictly higher; a tie goes to the newer live target.
    assign sel_target = (pend_prio > live_prio) ? pend_target : live_target;

    // Align down first so an unaligned redirect target realigns on the next advance.
    assign seq_pc = (pc_reg & GROUP_MASK) + 32'(GROUP_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc_reg      <= PC_INITIAL;
            pc_valid    <= 1'b0;
            pend_prio   <= PRIO_NONE;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc_reg      <= pc_next;
            pc_valid    <= 1'b1;
            pend_prio   <= pend_prio_next;
            pend_target <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc_reg;
        pend_prio_next   = pend_prio;
        pend_target_next = pend_target;

        if (debug_reset) begin
            state_next       = RUN;
            pc_next          = PC_INITIAL;
            pend_prio_next   = PRIO_NONE;
            pend_target_next = '0;
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        pc_next = (live_prio != PRIO_NONE) ? live_target : seq_pc;
                    end else if (live_prio != PRIO_NONE) begin
                        pend_prio_next   = live_prio;
                        pend_target_next = live_target;
                        state_next       = HOLD;
                    end
                end
                HOLD: begin
                    if (enable) begin
                        pc_next          = sel_target;
                        pend_prio_next   = PRIO_NONE;
                        pend_target_next = '0;
                        state_next       = RUN;
                    end else if (live_prio >= pend_prio) begin
                        // Lower-priority live requests are dropped while parked.
                        pend_prio_next   = live_prio;
                        pend_target_next = live_target;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign redirect_pending = (state == HOLD);
    assign pc_misaligned    = (pc_reg[1:0] != 2'b00);

    // Slot index of pc_reg within its fetch group.
    generate
        if (FETCH_WIDTH > 1) begin : g_slot_idx
            assign slot_idx = 32'(pc_reg[OFS_W+1:2]);
        end else begin : g_slot_idx_single
            assign slot_idx = '0;
        end
    endgenerate

    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_valid[i] = pc_valid && !pc_misaligned && (32'(i) >= slot_idx);
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen with FETCH_WIDTH=2.
//
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, well away from the next active edge.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        debug_reset;
    logic        is_debug;
    logic [31:0] debug_new_pc;
    logic        is_exception;
    logic [31:0] exception_new_pc;
    logic        is_branch;
    logic [31:0] branch_address;
    logic [31:0] pc_reg;
    logic        pc_valid;
    logic [1:0]  slot_valid;
    logic        pc_misaligned;
    logic        redirect_pending;

    int n_cmp = 0;
    int n_mis = 0;

    pc_gen #(
        .PC_INITIAL (32'hbfc00000),
        .FETCH_WIDTH(2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .debug_reset     (debug_reset),
        .is_debug        (is_debug),
        .debug_new_pc    (debug_new_pc),
        .is_exception    (is_exception),
        .exception_new_pc(exception_new_pc),
        .is_branch       (is_branch),
        .branch_address  (branch_address),
        .pc_reg          (pc_reg),
        .pc_valid        (pc_valid),
        .slot_valid      (slot_valid),
        .pc_misaligned   (pc_misaligned),
        .redirect_pending(redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        debug_reset      = 1'b0;
        is_debug         = 1'b0;
        debug_new_pc     = '0;
        is_exception     = 1'b0;
        exception_new_pc = '0;
        is_branch        = 1'b0;
        branch_address   = '0;

        // 1: reset state, then sequential advance
        #12;
        chk("rst_pc",       pc_reg, 32'hbfc00000);
        chk("rst_valid",    {31'd0, pc_valid}, 32'd0);
        chk("rst_slot",     {30'd0, slot_valid}, 32'd0);
        chk("rst_pending",  {31'd0, redirect_pending}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
        chk("seq1_pc",      pc_reg, 32'hbfc00008);
        chk("seq1_valid",   {31'd0, pc_valid}, 32'd1);
        chk("seq1_slot",    {30'd0, slot_valid}, 32'd3);
        step();
        chk("seq2_pc",      pc_reg, 32'hbfc00010);
        step();
        chk("seq3_pc",      pc_reg, 32'hbfc00018);

        // 2: live branch to upper slot of a group, then realign
        is_branch      = 1'b1;
        branch_address = 32'h80001004;
        step();
        chk("br_pc",        pc_reg, 32'h80001004);
        chk("br_slot",      {30'd0, slot_valid}, 32'd2);
        is_branch = 1'b0;
        step();
        chk("br_next_pc",   pc_reg, 32'h80001008);
        chk("br_next_slot", {30'd0, slot_valid}, 32'd3);

        // 3: stalled branch overwritten by stalled exception
        enable         = 1'b0;
        is_branch      = 1'b1;
        branch_address = 32'h80002000;
        step();
        chk("st_br_pend",   {31'd0, redirect_pending}, 32'd1);
        chk("st_br_hold",   pc_reg, 32'h80001008);
        is_branch        = 1'b0;
        is_exception     = 1'b1;
        exception_new_pc = 32'hbfc00380;
        step();
        chk("st_ex_pend",   {31'd0, redirect_pending}, 32'd1);
        chk("st_ex_hold",   pc_reg, 32'h80001008);
        is_exception = 1'b0;
        enable       = 1'b1;
        step();
        chk("st_rel_pc",    pc_reg, 32'hbfc00380);
        chk("st_rel_pend",  {31'd0, redirect_pending}, 32'd0);

        // 4: parked exception beats live branch; lower live request dropped in HOLD
        enable           = 1'b0;
        is_exception     = 1'b1;
        exception_new_pc = 32'h9fc00100;
        step();
        is_exception   = 1'b0;
        is_branch      = 1'b1;
        branch_address = 32'h80005000;
        step();
        chk("drop_pend",    {31'd0, redirect_pending}, 32'd1);
        enable         = 1'b1;
        branch_address = 32'h80003000;
        step();
        chk("pend_vs_br",   pc_reg, 32'h9fc00100);
        chk("pend_vs_br_p", {31'd0, redirect_pending}, 32'd0);
        // live debug beats parked exception
        enable           = 1'b0;
        is_branch        = 1'b0;
        is_exception     = 1'b1;
        exception_new_pc = 32'h9fc00200;
        step();
        is_exception = 1'b0;
        enable       = 1'b1;
        is_debug     = 1'b1;
        debug_new_pc = 32'hff200000;
        step();
        chk("dbg_vs_pend",  pc_reg, 32'hff200000);
        is_debug = 1'b0;
        // tie: live exception replaces parked exception target
        enable           = 1'b0;
        is_exception     = 1'b1;
        exception_new_pc = 32'h9fc00300;
        step();
        enable           = 1'b1;
        exception_new_pc = 32'h9fc00400;
        step();
        chk("tie_live",     pc_reg, 32'h9fc00400);
        is_exception = 1'b0;

        // 5: misaligned target, realign, debug_reset during HOLD
        is_branch      = 1'b1;
        branch_address = 32'h80000002;
        step();
        chk("mis_pc",       pc_reg, 32'h80000002);
        chk("mis_flag",     {31'd0, pc_misaligned}, 32'd1);
        chk("mis_slot",     {30'd0, slot_valid}, 32'd0);
        is_branch = 1'b0;
        step();
        chk("realign_pc",   pc_reg, 32'h80000008);
        chk("realign_flag", {31'd0, pc_misaligned}, 32'd0);
        enable         = 1'b0;
        is_branch      = 1'b1;
        branch_address = 32'h80004000;
        step();
        chk("dr_pend_set",  {31'd0, redirect_pending}, 32'd1);
        is_branch   = 1'b0;
        debug_reset = 1'b1;
        step();
        chk("dr_pc",        pc_reg, 32'hbfc00000);
        chk("dr_pend",      {31'd0, redirect_pending}, 32'd0);
        debug_reset = 1'b0;
        step();
        chk("stall_hold",   pc_reg, 32'hbfc00000);

        // 6: wrap at top of address space, then asynchronous reset
        enable         = 1'b1;
        is_branch      = 1'b1;
        branch_address = 32'hfffffff8;
        step();
        chk("wrap_pre",     pc_reg, 32'hfffffff8);
        is_branch = 1'b0;
        step();
        chk("wrap_pc",      pc_reg, 32'h00000000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc",     pc_reg, 32'hbfc00000);
        chk("async_valid",  {31'd0, pc_valid}, 32'd0);
        chk("async_slot",   {30'd0, slot_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
